// File: rtl/hadamard4pt_inverse.sv
// Pipelined 4-point inverse Hadamard transform: x = (H*y)/4 with a three-register pipeline,
// flagging coefficient sets that are non-exact (not divisible by 4) or out of output range.
module hadamard4pt_inverse #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  y0,
    input  logic signed [IN_W-1:0]  y1,
    input  logic signed [IN_W-1:0]  y2,
    input  logic signed [IN_W-1:0]  y3,
    output logic signed [OUT_W-1:0] x0,
    output logic signed [OUT_W-1:0] x1,
    output logic signed [OUT_W-1:0] x2,
    output logic signed [OUT_W-1:0] x3,
    output logic                    done,
    output logic                    err,
    output logic                    err_sticky
);

    localparam int unsigned AW = IN_W + 1;
    localparam int unsigned SW = IN_W + 2;

    localparam logic signed [SW-1:0] MaxQ = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] MinQ = SW'(-(1 << (OUT_W - 1)));

    logic signed [AW-1:0]    a_q [4];
    logic signed [AW-1:0]    a_d [4];
    logic signed [SW-1:0]    s_q [4];
    logic signed [SW-1:0]    s_d [4];
    logic signed [OUT_W-1:0] x_q [4];
    logic signed [OUT_W-1:0] x_d [4];
    logic                    v1_q, v2_q, done_q, err_q, err_d, err_sticky_q;

    // Returns {lane_error, saturated_sample} for one lane holding 4*x.
    function automatic logic [OUT_W:0] recon(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
        logic                 inexact, hi, lo;
        logic [OUT_W-1:0]     x;
        q       = s >>> 2;
        inexact = |s[1:0];
        hi      = (q > MaxQ);
        lo      = (q < MinQ);
        if (hi) begin
            x = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (lo) begin
            x = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            x = q[OUT_W-1:0];
        end
        return {inexact | hi | lo, x};
    endfunction

    always_comb begin
        a_d[0] = {y0[IN_W-1], y0} + {y1[IN_W-1], y1};
        a_d[1] = {y0[IN_W-1], y0} - {y1[IN_W-1], y1};
        a_d[2] = {y2[IN_W-1], y2} + {y3[IN_W-1], y3};
        a_d[3] = {y2[IN_W-1], y2} - {y3[IN_W-1], y3};
    end

    always_comb begin
        s_d[0] = {a_q[0][AW-1], a_q[0]} + {a_q[2][AW-1], a_q[2]};
        s_d[1] = {a_q[1][AW-1], a_q[1]} + {a_q[3][AW-1], a_q[3]};
        s_d[2] = {a_q[0][AW-1], a_q[0]} - {a_q[2][AW-1], a_q[2]};
        s_d[3] = {a_q[1][AW-1], a_q[1]} - {a_q[3][AW-1], a_q[3]};
    end

    always_comb begin
        logic [OUT_W:0] r;
        err_d = 1'b0;
        r     = '0;
        for (int i = 0; i < 4; i++) begin
            r      = recon(s_q[i]);
            x_d[i] = r[OUT_W-1:0];
            err_d  = err_d | r[OUT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                s_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            v1_q   <= start;
            v2_q   <= v1_q;
            done_q <= v2_q;
            // Each stage holds unless its incoming valid bit is set.
            if (start) begin
                for (int i = 0; i < 4; i++) a_q[i] <= a_d[i];
            end
            if (v1_q) begin
                for (int i = 0; i < 4; i++) s_q[i] <= s_d[i];
            end
            if (v2_q) begin
                for (int i = 0; i < 4; i++) x_q[i] <= x_d[i];
                err_q        <= err_d;
                err_sticky_q <= err_sticky_q | err_d;
            end
        end
    end

    assign x0         = x_q[0];
    assign x1         = x_q[1];
    assign x2         = x_q[2];
    assign x3         = x_q[3];
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_hadamard4pt_inverse.sv
// Directed bench for hadamard4pt_inverse: exact reconstruction, streaming, extremes,
// non-exact and saturating inputs, and asynchronous reset mid-pipeline.
module tb_hadamard4pt_inverse;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [9:0] y0, y1, y2, y3;
    logic signed [7:0] x0, x1, x2, x3;
    logic              done, err, err_sticky;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hadamard4pt_inverse #(
        .IN_W (10),
        .OUT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .done      (done),
        .err       (err),
        .err_sticky(err_sticky)
    );

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input int c, input int d, input logic s);
        y0    = 10'(a);
        y1    = 10'(b);
        y2    = 10'(c);
        y3    = 10'(d);
        start = s;
    endtask

    // Pulse start for one edge, then check done timing, result and err at the third edge.
    task automatic single(input string name, input int a, input int b, input int c, input int d,
                          input logic [31:0] want_x, input logic want_err);
        drive(a, b, c, d, 1'b1);
        step();
        drive(0, 0, 0, 0, 1'b0);
        step();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s_early_done: got %b want 0", name, done);
        end
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: got %b want 1", name, done);
        end
        tests++;
        if ({x0, x1, x2, x3} !== want_x) begin
            fails++;
            $display("FAIL %s_x: got %h want %h", name, {x0, x1, x2, x3}, want_x);
        end
        tests++;
        if (err !== want_err) begin
            fails++;
            $display("FAIL %s_err: got %b want %b", name, err, want_err);
        end
        step();
        tests++;
        if (done !== 1'b0 || {x0, x1, x2, x3} !== want_x) begin
            fails++;
            $display("FAIL %s_hold: got done=%b x=%h want done=0 x=%h", name, done,
                     {x0, x1, x2, x3}, want_x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        tests++;
        if ({x0, x1, x2, x3, done, err, err_sticky} !== 35'd0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0", {x0, x1, x2, x3, done, err, err_sticky});
        end
    endtask

    task automatic test_exact();
        single("exact_a", 6, -4, 8, 2, pack(3, 4, -2, 1), 1'b0);
        single("exact_b", 11, -9, -1, -5, pack(-1, 6, 2, 4), 1'b0);
        tests++;
        if (err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL exact_sticky: got %b want 0", err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        drive(3, 9, 1, 7, 1'b1);
        step();
        drive(-11, 5, 1, -3, 1'b1);
        step();
        drive(0, 0, 0, 0, 1'b0);
        step();
        tests++;
        if (done !== 1'b1 || {x0, x1, x2, x3} !== pack(5, -3, 1, 0) || err !== 1'b0) begin
            fails++;
            $display("FAIL stream_first: got done=%b x=%h err=%b want done=1 x=%h err=0",
                     done, {x0, x1, x2, x3}, err, pack(5, -3, 1, 0));
        end
        step();
        tests++;
        if (done !== 1'b1 || {x0, x1, x2, x3} !== pack(-2, -3, -1, -5) || err !== 1'b0) begin
            fails++;
            $display("FAIL stream_second: got done=%b x=%h err=%b want done=1 x=%h err=0",
                     done, {x0, x1, x2, x3}, err, pack(-2, -3, -1, -5));
        end
        step();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL stream_end: got %b want 0", done);
        end
    endtask

    task automatic test_extremes();
        single("ext_neg", -512, 0, 0, 0, pack(-128, -128, -128, -128), 1'b0);
        single("ext_pos", 508, 0, 0, 0, pack(127, 127, 127, 127), 1'b0);
    endtask

    task automatic test_nonexact();
        single("inexact", 1, 0, 0, 0, pack(0, 0, 0, 0), 1'b1);
        tests++;
        if (err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL inexact_sticky: got %b want 1", err_sticky);
        end
        single("clean_after", 6, -4, 8, 2, pack(3, 4, -2, 1), 1'b0);
        tests++;
        if (err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_holds: got %b want 1", err_sticky);
        end
    endtask

    task automatic test_saturation();
        single("sat", 511, 511, 511, 511, pack(127, 0, 0, 0), 1'b1);
    endtask

    task automatic test_reset_midflight();
        drive(11, -9, -1, -5, 1'b1);
        step();
        drive(0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({x0, x1, x2, x3, done, err, err_sticky} !== 35'd0) begin
            fails++;
            $display("FAIL midreset_clear: got %h want 0", {x0, x1, x2, x3, done, err, err_sticky});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL midreset_no_done[%0d]: got %b want 0", i, done);
            end
        end
        single("post_reset", 11, -9, -1, -5, pack(-1, 6, 2, 4), 1'b0);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_back_to_back();
        test_extremes();
        test_nonexact();
        test_saturation();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
